uart_frac_baud_gen: RTL

// - Programmable fractional baud generator for the configurable UART; replaces fixed 4-rate divider.
// - Emits 1-cycle oversample tick, TX bit tick, RX mid-bit sample tick; divisor reprogrammable at runtime, applied glitch-free.
// - Feeds UART TX/RX FSMs; divisor driven from the UART config register block.

---
 rtl/uart_frac_baud_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frac_baud_gen.sv
// Fractional UART baud generator: oversample, TX bit and RX mid-bit ticks from a runtime divisor.
// Optional macro UART_BAUD_SQUARE_EN adds baud_clk, a square wave toggled on every tx_tick.
module uart_frac_baud_gen #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVS         = 16,
    parameter int DEFAULT_DIV = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    input  logic              rx_resync,
    output logic              div_pending,
    output logic              os_tick,
    output logic              tx_tick,
    output logic              rx_tick
`ifdef UART_BAUD_SQUARE_EN
    ,
    output logic              baud_clk
`endif
);

    localparam int CNT_W = DIV_W + 1;
    localparam int PH_W  = $clog2(OVS);
    localparam logic [DIV_W-1:0]  DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  DIV_MIN = DIV_W'(32'd2);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]   PH_RX   = PH_W'(OVS / 2 - 1);

    logic [DIV_W-1:0]  act_int_r,  act_int_nxt_s;
    logic [FRAC_W-1:0] act_frac_r, act_frac_nxt_s;
    logic [DIV_W-1:0]  shd_int_r,  shd_int_nxt_s;
    logic [FRAC_W-1:0] shd_frac_r, shd_frac_nxt_s;
    logic              pend_r,     pend_nxt_s;
    logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
    logic [FRAC_W-1:0] acc_r,      acc_nxt_s;
    logic              ext_r,      ext_nxt_s;
    logic [PH_W-1:0]   tx_ph_r,    tx_ph_nxt_s;
    logic [PH_W-1:0]   rx_ph_r,    rx_ph_nxt_s;
    logic              os_tick_r,  os_tick_nxt_s;
    logic              tx_tick_r,  tx_tick_nxt_s;
    logic              rx_tick_r,  rx_tick_nxt_s;

    logic [DIV_W-1:0]  int_eff_s;
    logic [CNT_W-1:0]  last_s;
    logic              hit_s;
    logic              apply_s;
    logic [FRAC_W-1:0] frac_use_s;
    logic [FRAC_W:0]   sum_s;

`ifdef UART_BAUD_SQUARE_EN
    logic              baud_r, baud_nxt_s;
`endif

    // Interval timing, divisor shadow/apply and phase counters.
    always_comb begin
        act_int_nxt_s  = act_int_r;
        act_frac_nxt_s = act_frac_r;
        shd_int_nxt_s  = shd_int_r;
        shd_frac_nxt_s = shd_frac_r;
        pend_nxt_s     = pend_r;
        cnt_nxt_s      = cnt_r;
        acc_nxt_s      = acc_r;
        ext_nxt_s      = ext_r;
        tx_ph_nxt_s    = tx_ph_r;
        rx_ph_nxt_s    = rx_ph_r;
        os_tick_nxt_s  = 1'b0;
        tx_tick_nxt_s  = 1'b0;
        rx_tick_nxt_s  = 1'b0;
`ifdef UART_BAUD_SQUARE_EN
        baud_nxt_s     = baud_r;
`endif

        // Divisors below 2 would allow back-to-back ticks, so they are clamped.
        if (act_int_r < DIV_MIN) begin
            int_eff_s = DIV_MIN;
        end else begin
            int_eff_s = act_int_r;
        end
        last_s = {1'b0, int_eff_s} - CNT_W'(1'b1) + {{DIV_W{1'b0}}, ext_r};
        hit_s  = en & (cnt_r == last_s);

        if (en) begin
            apply_s = pend_r & hit_s;
        end else begin
            apply_s = pend_r;
        end

        // The frac applied at a tick decides the carry of the interval it starts.
        if (apply_s) begin
            frac_use_s     = shd_frac_r;
            act_int_nxt_s  = shd_int_r;
            act_frac_nxt_s = shd_frac_r;
        end else begin
            frac_use_s     = act_frac_r;
        end
        sum_s = {1'b0, acc_r} + {1'b0, frac_use_s};

        if (div_load) begin
            shd_int_nxt_s  = div_int;
            shd_frac_nxt_s = div_frac;
            pend_nxt_s     = 1'b1;
        end else if (apply_s) begin
            pend_nxt_s     = 1'b0;
        end else begin
            pend_nxt_s     = pend_r;
        end

        if (!en) begin
            cnt_nxt_s   = '0;
            acc_nxt_s   = '0;
            ext_nxt_s   = 1'b0;
            tx_ph_nxt_s = '0;
            rx_ph_nxt_s = '0;
`ifdef UART_BAUD_SQUARE_EN
            baud_nxt_s  = 1'b0;
`endif
        end else begin
            if (hit_s) begin
                cnt_nxt_s     = '0;
                acc_nxt_s     = sum_s[FRAC_W-1:0];
                ext_nxt_s     = sum_s[FRAC_W];
                os_tick_nxt_s = 1'b1;
                tx_ph_nxt_s   = tx_ph_r + PH_W'(1'b1);
                tx_tick_nxt_s = (tx_ph_r == PH_LAST);
`ifdef UART_BAUD_SQUARE_EN
                baud_nxt_s    = baud_r ^ (tx_ph_r == PH_LAST);
`endif
            end else begin
                cnt_nxt_s     = cnt_r + CNT_W'(1'b1);
            end
            // A resync overrides a coincident tick for the RX phase only.
            if (rx_resync) begin
                rx_ph_nxt_s   = '0;
            end else if (hit_s) begin
                rx_ph_nxt_s   = rx_ph_r + PH_W'(1'b1);
                rx_tick_nxt_s = (rx_ph_r == PH_RX);
            end else begin
                rx_ph_nxt_s   = rx_ph_r;
            end
        end
    end

    // State register with asynchronous reset to the default divisor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_int_r  <= DIV_RST;
            act_frac_r <= '0;
            shd_int_r  <= DIV_RST;
            shd_frac_r <= '0;
            pend_r     <= 1'b0;
            cnt_r      <= '0;
            acc_r      <= '0;
            ext_r      <= 1'b0;
            tx_ph_r    <= '0;
            rx_ph_r    <= '0;
            os_tick_r  <= 1'b0;
            tx_tick_r  <= 1'b0;
            rx_tick_r  <= 1'b0;
`ifdef UART_BAUD_SQUARE_EN
            baud_r     <= 1'b0;
`endif
        end else begin
            act_int_r  <= act_int_nxt_s;
            act_frac_r <= act_frac_nxt_s;
            shd_int_r  <= shd_int_nxt_s;
            shd_frac_r <= shd_frac_nxt_s;
            pend_r     <= pend_nxt_s;
            cnt_r      <= cnt_nxt_s;
            acc_r      <= acc_nxt_s;
            ext_r      <= ext_nxt_s;
            tx_ph_r    <= tx_ph_nxt_s;
            rx_ph_r    <= rx_ph_nxt_s;
            os_tick_r  <= os_tick_nxt_s;
            tx_tick_r  <= tx_tick_nxt_s;
            rx_tick_r  <= rx_tick_nxt_s;
`ifdef UART_BAUD_SQUARE_EN
            baud_r     <= baud_nxt_s;
`endif
        end
    end

    assign div_pending = pend_r;
    assign os_tick     = os_tick_r;
    assign tx_tick     = tx_tick_r;
    assign rx_tick     = rx_tick_r;
`ifdef UART_BAUD_SQUARE_EN
    assign baud_clk    = baud_r;
`endif

endmodule
